rv32_bus_arbiter: RTL and testbench
===================================

Name: rv32_bus_arbiter

Overview:
Bus responder that serves the core's instruction-fetch and data-memory initiator ports. It arbitrates both ports onto one shared downstream memory bus and returns per-port ready handshakes, which the core's stall logic consumes. A watchdog completes any transaction the downstream bus never answers, and flags it as a fault.

Parameters:
TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for bus_ready_in before forced completion; 0 disables the watchdog.
COUNT_WIDTH, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  reset, synchronous, active-low
instr_address_in  in  32  fetch address
instr_read_in  in  1  fetch request; held with address until instr_ready_out
instr_read_value_out  out  32  fetched word; valid only with instr_ready_out
instr_ready_out  out  1  fetch complete this cycle
instr_fault_out  out  1  fetch completed by watchdog
data_address_in  in  32  data address
data_read_in  in  1  load request
data_write_in  in  1  store request
data_write_mask_in  in  4  byte enables for stores
data_write_value_in  in  32  store data
data_read_value_out  out  32  load data; valid only with data_ready_out
data_ready_out  out  1  data access complete this cycle
data_fault_out  out  1  data access completed by watchdog
bus_address_out  out  32  shared bus address
bus_read_out  out  1  shared bus read strobe
bus_write_out  out  1  shared bus write strobe
bus_write_mask_out  out  4  shared bus byte enables
bus_write_value_out  out  32  shared bus write data
bus_read_value_in  in  32  shared bus read data
bus_ready_in  in  1  shared bus completion

Behaviour:
- Reset (reset_n low at a clock edge):
  - state goes to IDLE and the watchdog counter clears;
  - while in IDLE all outputs are 0: strobes, readies, faults, read values, address, mask and write value.
- Reset mid-transaction: the transaction is abandoned with no ready pulse; bus strobes drop the cycle after the reset edge.
- Data request: data_pend = data_read_in | data_write_in. Fetch request: instr_pend = instr_read_in.
- States:
  - IDLE: no grant.
  - INSTR: fetch port owns the bus.
  - DATA: data port owns the bus.
- IDLE transitions:
  - data_pend, with or without instr_pend -> DATA (data wins ties from idle);
  - else instr_pend -> INSTR;
  - else stay in IDLE.
  - No bus strobe is driven in IDLE, so minimum latency from idle is request at cycle N, strobe at N+1, ready at N+1 if bus_ready_in is high.
- INSTR/DATA outputs:
  - bus address, strobes, mask and write value are combinational pass-through of the owner's inputs;
  - the INSTR grant drives bus_write_out=0 and mask=0;
  - owner ready = bus_ready_in; owner read value = bus_read_value_in when ready, else 0;
  - the non-owner's ready, fault and read value are 0.
- Completion (owner ready high) picks the next state in the same edge, so back-to-back transactions have no bubble. Alternating priority:
  - after DATA: instr_pend -> INSTR; else data_pend -> DATA; else IDLE;
  - after INSTR: data_pend -> DATA; else instr_pend -> INSTR; else IDLE.
- Request sampling at completion: the pending signals sampled are the inputs in the completing cycle, including the owner's own still-asserted strobe. The requester drops or changes its request the cycle after ready.
- Abort: if the owner's strobe(s) deassert before ready, the next state is IDLE and no ready is issued.
- Watchdog:
  - the counter clears on every grant or state change and increments each granted cycle with bus_ready_in low;
  - when counter == TIMEOUT_CYCLES and bus_ready_in is low, owner ready=1, owner fault=1 and read value=0 for that cycle; next state is chosen as for a normal completion;
  - if bus_ready_in and the timeout coincide, it is a normal completion with fault=0;
  - the counter saturates and does not wrap.
- A fault pulse is exactly one cycle and only ever accompanies ready.
- A read and a write from the data port in the same cycle is illegal; both strobes pass through unchanged.

Test Plan:
1. Reset_n low 2 cycles with both requests high -> all outputs 0. Release reset -> DATA granted, bus_read_out=1 in the first cycle after release, instr_ready_out=0.
2. Fetch only, addr 0x100, bus_ready_in high with bus_read_value_in=0x00000013 -> strobe 1 cycle after request; instr_ready_out=1 and value 0x13 in that cycle; bus idle next cycle once the request drops.
3. Both ports held requesting, bus_ready_in always 1 -> grants alternate D,I,D,I on consecutive cycles with no IDLE cycle; each ready is a single-cycle pulse.
4. Store addr 0x2000, mask 0b0011, value 0xDEADBEEF, bus_ready_in delayed 3 cycles -> bus outputs stable for 4 cycles; data_ready_out only on the 4th; instr held off throughout.
5. TIMEOUT_CYCLES=4, bus_ready_in stuck low on a fetch -> instr_ready_out=1 and instr_fault_out=1 in the 5th granted cycle, read value 0; then a fault-free access succeeds.
6. Fetch granted, instr_read_in dropped after 1 cycle with no bus_ready_in -> returns to IDLE, no instr_ready_out pulse; a pending data request is granted next.

Source files
------------

// File: rtl/rv32_bus_arbiter.sv
// rtl/rv32_bus_arbiter.sv - fetch/data arbiter onto one shared memory bus with watchdog
// Alternating priority between ports; watchdog force-completes stalled grants with a fault.
module rv32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   data_pend, instr_pend, owner_pend, timeout, done;

  always_comb begin
    data_pend            = data_read_in | data_write_in;
    instr_pend           = instr_read_in;
    state_d              = state_q;
    owner_pend           = 1'b0;
    bus_address_out      = '0;
    bus_read_out         = 1'b0;
    bus_write_out        = 1'b0;
    bus_write_mask_out   = '0;
    bus_write_value_out  = '0;
    instr_ready_out      = 1'b0;
    instr_fault_out      = 1'b0;
    instr_read_value_out = '0;
    data_ready_out       = 1'b0;
    data_fault_out       = 1'b0;
    data_read_value_out  = '0;

    case (state_q)
      INSTR: begin
        owner_pend      = instr_pend;
        bus_address_out = instr_address_in;
        bus_read_out    = instr_read_in;
      end
      DATA: begin
        owner_pend          = data_pend;
        bus_address_out     = data_address_in;
        bus_read_out        = data_read_in;
        bus_write_out       = data_write_in;
        bus_write_mask_out  = data_write_mask_in;
        bus_write_value_out = data_write_value_in;
      end
      default: ;
    endcase

    // A real bus answer always beats the watchdog when both land together.
    timeout = (TIMEOUT_CYCLES != 0) && owner_pend && (cnt_q == TIMEOUT_VAL) && !bus_ready_in;
    done    = owner_pend && (bus_ready_in || timeout);

    case (state_q)
      IDLE: begin
        if (data_pend)       state_d = DATA;
        else if (instr_pend) state_d = INSTR;
      end
      INSTR: begin
        instr_ready_out      = done;
        instr_fault_out      = timeout;
        instr_read_value_out = (owner_pend && bus_ready_in) ? bus_read_value_in : '0;
        if (!owner_pend)     state_d = IDLE;
        else if (done)       state_d = data_pend ? DATA : INSTR;
      end
      DATA: begin
        data_ready_out      = done;
        data_fault_out      = timeout;
        data_read_value_out = (owner_pend && bus_ready_in) ? bus_read_value_in : '0;
        if (!owner_pend)     state_d = IDLE;
        else if (done)       state_d = instr_pend ? INSTR : DATA;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || done || state_d != state_q)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// tb/tb_rv32_bus_arbiter.sv - bench for rv32_bus_arbiter
// Vector table, directed stall/timeout sequences, and random traffic against a transaction model.
module tb_rv32_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_address_in, instr_read_value_out;
  logic        instr_read_in, instr_ready_out, instr_fault_out;
  logic [31:0] data_address_in, data_write_value_in, data_read_value_out;
  logic        data_read_in, data_write_in, data_ready_out, data_fault_out;
  logic [3:0]  data_write_mask_in, bus_write_mask_out;
  logic [31:0] bus_address_out, bus_write_value_out, bus_read_value_in;
  logic        bus_read_out, bus_write_out, bus_ready_in;

  always #5 clk = ~clk;

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_address_in(instr_address_in), .instr_read_in(instr_read_in),
    .instr_read_value_out(instr_read_value_out), .instr_ready_out(instr_ready_out),
    .instr_fault_out(instr_fault_out),
    .data_address_in(data_address_in), .data_read_in(data_read_in),
    .data_write_in(data_write_in), .data_write_mask_in(data_write_mask_in),
    .data_write_value_in(data_write_value_in), .data_read_value_out(data_read_value_out),
    .data_ready_out(data_ready_out), .data_fault_out(data_fault_out),
    .bus_address_out(bus_address_out), .bus_read_out(bus_read_out),
    .bus_write_out(bus_write_out), .bus_write_mask_out(bus_write_mask_out),
    .bus_write_value_out(bus_write_value_out), .bus_read_value_in(bus_read_value_in),
    .bus_ready_in(bus_ready_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: owner 0 = nobody, 1 = fetch port, 2 = data port.
  int           m_owner  = 0;
  int           m_waited = 0;
  logic         m_irdy, m_drdy;
  logic [137:0] m_out;

  function automatic logic pend(int p);
    return (p == 1) ? instr_read_in : (data_read_in | data_write_in);
  endfunction

  task automatic model_eval();
    logic [31:0] a, wv, iv, dv;
    logic [3:0]  mk;
    logic        rd, wr, ir, ifl, dr, dfl, wd;
    a = '0; wv = '0; iv = '0; dv = '0; mk = '0;
    rd = 0; wr = 0; ir = 0; ifl = 0; dr = 0; dfl = 0;
    if (m_owner == 1) begin
      a = instr_address_in; rd = instr_read_in;
    end else if (m_owner == 2) begin
      a = data_address_in; rd = data_read_in; wr = data_write_in;
      mk = data_write_mask_in; wv = data_write_value_in;
    end
    wd = (m_owner != 0) && pend(m_owner) && (TO != 0) && (m_waited == TO) && !bus_ready_in;
    if (m_owner != 0 && pend(m_owner) && (bus_ready_in || wd)) begin
      if (m_owner == 1) begin
        ir = 1; ifl = wd; iv = bus_ready_in ? bus_read_value_in : 32'h0;
      end else begin
        dr = 1; dfl = wd; dv = bus_ready_in ? bus_read_value_in : 32'h0;
      end
    end
    m_irdy = ir;
    m_drdy = dr;
    m_out  = {a, rd, wr, mk, wv, ir, ifl, iv, dr, dfl, dv};
  endtask

  task automatic model_update();
    int served;
    if (!reset_n) begin
      m_owner = 0; m_waited = 0;
    end else if (m_owner == 0) begin
      m_owner  = pend(2) ? 2 : (pend(1) ? 1 : 0);
      m_waited = 0;
    end else if (!pend(m_owner)) begin
      m_owner = 0; m_waited = 0;
    end else if (m_irdy || m_drdy) begin
      served = m_owner;
      if (pend(3 - served))  m_owner = 3 - served;
      else if (pend(served)) m_owner = served;
      else                   m_owner = 0;
      m_waited = 0;
    end else if (m_waited < 255) begin
      m_waited++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("model", {bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out,
                  bus_write_value_out, instr_ready_out, instr_fault_out, instr_read_value_out,
                  data_ready_out, data_fault_out, data_read_value_out}, m_out);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic rst, input logic ird, input logic [31:0] iaddr,
                        input logic drd, input logic dwr, input logic [31:0] daddr,
                        input logic [3:0] mask, input logic [31:0] wval,
                        input logic brdy, input logic [31:0] bval);
    reset_n = rst; instr_read_in = ird; instr_address_in = iaddr;
    data_read_in = drd; data_write_in = dwr; data_address_in = daddr;
    data_write_mask_in = mask; data_write_value_in = wval;
    bus_ready_in = brdy; bus_read_value_in = bval;
  endtask

  typedef struct {
    logic        rst, ird, drd, brdy;
    logic [31:0] iaddr, daddr, bval;
    logic [31:0] e_addr, e_ival, e_dval;
    logic        e_rd, e_irdy, e_drdy;
  } vec_t;

  function automatic vec_t mkv(logic rst, logic ird, logic [31:0] iaddr, logic drd,
                               logic [31:0] daddr, logic brdy, logic [31:0] bval,
                               logic [31:0] e_addr, logic e_rd, logic e_irdy,
                               logic [31:0] e_ival, logic e_drdy, logic [31:0] e_dval);
    vec_t v;
    v.rst = rst; v.ird = ird; v.iaddr = iaddr; v.drd = drd; v.daddr = daddr;
    v.brdy = brdy; v.bval = bval; v.e_addr = e_addr; v.e_rd = e_rd;
    v.e_irdy = e_irdy; v.e_ival = e_ival; v.e_drdy = e_drdy; v.e_dval = e_dval;
    return v;
  endfunction

  vec_t tbl [17];
  logic keep_i, keep_d;
  int   op;

  initial begin
    tbl[0]  = mkv(0, 1, 32'h40,  1, 32'h80,  0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[1]  = mkv(0, 1, 32'h40,  1, 32'h80,  0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[2]  = mkv(1, 1, 32'h40,  1, 32'h80,  0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[3]  = mkv(1, 1, 32'h40,  1, 32'h80,  1, 32'h11, 32'h80,  1, 0, 32'h0,  1, 32'h11);
    tbl[4]  = mkv(1, 1, 32'h40,  1, 32'h80,  1, 32'h22, 32'h40,  1, 1, 32'h22, 0, 32'h0);
    tbl[5]  = mkv(1, 1, 32'h40,  1, 32'h80,  1, 32'h33, 32'h80,  1, 0, 32'h0,  1, 32'h33);
    tbl[6]  = mkv(1, 1, 32'h40,  1, 32'h80,  1, 32'h44, 32'h40,  1, 1, 32'h44, 0, 32'h0);
    tbl[7]  = mkv(1, 0, 32'h0,   0, 32'h0,   0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[8]  = mkv(1, 1, 32'h100, 0, 32'h0,   1, 32'h13, 32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[9]  = mkv(1, 1, 32'h100, 0, 32'h0,   1, 32'h13, 32'h100, 1, 1, 32'h13, 0, 32'h0);
    tbl[10] = mkv(1, 0, 32'h0,   0, 32'h0,   0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[11] = mkv(1, 1, 32'h200, 0, 32'h0,   0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[12] = mkv(1, 1, 32'h200, 1, 32'h300, 0, 32'h0,  32'h200, 1, 0, 32'h0,  0, 32'h0);
    tbl[13] = mkv(1, 0, 32'h200, 1, 32'h300, 0, 32'h0,  32'h200, 0, 0, 32'h0,  0, 32'h0);
    tbl[14] = mkv(1, 0, 32'h0,   1, 32'h300, 0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);
    tbl[15] = mkv(1, 0, 32'h0,   1, 32'h300, 1, 32'h55, 32'h300, 1, 0, 32'h0,  1, 32'h55);
    tbl[16] = mkv(1, 0, 32'h0,   0, 32'h0,   0, 32'h0,  32'h0,   0, 0, 32'h0,  0, 32'h0);

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].rst, tbl[i].ird, tbl[i].iaddr, tbl[i].drd, 1'b0, tbl[i].daddr,
             4'h0, 32'h0, tbl[i].brdy, tbl[i].bval);
      sample();
      chk($sformatf("vec%0d", i),
          {bus_address_out, bus_read_out, bus_write_out, instr_ready_out, instr_fault_out,
           instr_read_value_out, data_ready_out, data_fault_out, data_read_value_out},
          {tbl[i].e_addr, tbl[i].e_rd, 1'b0, tbl[i].e_irdy, 1'b0, tbl[i].e_ival,
           tbl[i].e_drdy, 1'b0, tbl[i].e_dval});
      advance();
    end

    // Store stalled three cycles with a fetch waiting behind it.
    set_in(1, 1, 32'h500, 0, 1, 32'h2000, 4'b0011, 32'hDEADBEEF, 0, 32'h0);
    sample();
    chk("st_idle_wr", bus_write_out, 1'b0);
    advance();
    for (int k = 0; k < 4; k++) begin
      bus_ready_in = (k == 3);
      sample();
      chk($sformatf("st_bus%0d", k),
          {bus_address_out, bus_write_out, bus_read_out, bus_write_mask_out, bus_write_value_out},
          {32'h2000, 1'b1, 1'b0, 4'b0011, 32'hDEADBEEF});
      chk($sformatf("st_rdy%0d", k), {data_ready_out, data_fault_out, instr_ready_out},
          {(k == 3), 1'b0, 1'b0});
      advance();
    end
    set_in(1, 1, 32'h500, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h77);
    sample();
    chk("st_then_fetch", {instr_ready_out, instr_read_value_out, bus_address_out},
        {1'b1, 32'h77, 32'h500});
    advance();
    set_in(1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
    sample();
    advance();

    // Fetch with a dead bus: watchdog completes it on the fifth granted cycle.
    set_in(1, 1, 32'h600, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'hBAD);
    sample();
    advance();
    for (int k = 1; k <= 5; k++) begin
      sample();
      chk($sformatf("wd_cyc%0d", k),
          {bus_read_out, instr_ready_out, instr_fault_out, instr_read_value_out},
          {1'b1, (k == 5), (k == 5), 32'h0});
      advance();
    end
    set_in(1, 0, 32'h600, 1, 0, 32'h700, 4'h0, 32'h0, 0, 32'h0);
    sample();
    chk("wd_drop", {instr_ready_out, instr_fault_out, bus_read_out}, 3'b000);
    advance();
    set_in(1, 0, 32'h0, 1, 0, 32'h700, 4'h0, 32'h0, 1, 32'h99);
    sample();
    advance();
    sample();
    chk("wd_recover", {data_ready_out, data_fault_out, data_read_value_out, bus_address_out},
        {1'b1, 1'b0, 32'h99, 32'h700});
    advance();
    set_in(1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
    sample();
    advance();

    // Random traffic; requests are mostly held until the model says they completed.
    keep_i = 0;
    keep_d = 0;
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if (!keep_i || $urandom_range(0, 19) == 0) begin
        instr_read_in    = ($urandom_range(0, 1) == 1);
        instr_address_in = $urandom;
      end
      if (!keep_d || $urandom_range(0, 19) == 0) begin
        op                  = $urandom_range(0, 7);
        data_read_in        = (op == 3 || op == 4 || op == 7);
        data_write_in       = (op == 5 || op == 6 || op == 7);
        data_address_in     = $urandom;
        data_write_mask_in  = 4'($urandom);
        data_write_value_in = $urandom;
      end
      bus_ready_in      = ($urandom_range(0, 2) == 0);
      bus_read_value_in = $urandom;
      sample();
      keep_i = !m_irdy;
      keep_d = !m_drdy;
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
